// File: rtl/kd_pkg.sv
// kd_pkg: shared widths, state encoding and defaults for the kd-tree k-means array.
package kd_pkg;
   localparam int DIM_DEF = 3;
   localparam int DATA_RANGE_DEF = 255;
   localparam int MAX_N_DEF = 1000;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DIV = 2'd1;
   localparam logic [1:0] ST_CMP = 2'd2;
   function automatic int dim_w(input int range);
      return $clog2(range);
   endfunction
   function automatic int cnt_w(input int n);
      return $clog2(n);
   endfunction
   function automatic int acc_w(input int range, input int n);
      return dim_w(range) + cnt_w(n);
   endfunction
endpackage

// File: rtl/center_div_lane.sv
// center_div_lane: one MSB-first restoring divider lane with quotient saturation.
module center_div_lane #(
   parameter int DIM_W = 8,
   parameter int CNT_W = 10,
   parameter int ACC_W = 18,
   parameter int DATA_RANGE = 255
) (
   input  logic             clk,
   input  logic             load,
   input  logic             step,
   input  logic [ACC_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic [DIM_W-1:0] quotient
);
   logic [ACC_W-1:0] dvd_q, q_q;
   logic [CNT_W-1:0] dvs_q;
   logic [CNT_W:0]   rem_q, rem_sh;
   logic             ge;
   // rem stays below the divisor, so dropping its top bit before the shift loses nothing
   assign rem_sh = {rem_q[CNT_W-1:0], dvd_q[ACC_W-1]};
   assign ge = rem_sh >= {1'b0, dvs_q};
   assign quotient = q_q > ACC_W'(DATA_RANGE) ? DIM_W'(DATA_RANGE) : q_q[DIM_W-1:0];
   always_ff @(posedge clk) begin
      if (load) begin
         dvd_q <= dividend;
         dvs_q <= divisor;
         q_q <= '0;
         rem_q <= '0;
      end else if (step) begin
         dvd_q <= dvd_q << 1;
         rem_q <= ge ? rem_sh - {1'b0, dvs_q} : rem_sh;
         q_q <= {q_q[ACC_W-2:0], ge};
      end
   end
endmodule

// File: rtl/center_update.sv
// center_update: divides per-axis accumulators by the point count and flags
// whether the new center stayed within tol of the old one.
module center_update
   import kd_pkg::*;
#(
   parameter int DIM = DIM_DEF,
   parameter int DATA_RANGE = DATA_RANGE_DEF,
   parameter int MAX_N = MAX_N_DEF,
   parameter int TOL = 0,
   localparam int DIM_W = dim_w(DATA_RANGE),
   localparam int CNT_W = cnt_w(MAX_N),
   localparam int ACC_W = acc_w(DATA_RANGE, MAX_N),
   localparam int CENTER_W = DIM * DIM_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DIM*ACC_W-1:0] acc_in,
   input  logic [CNT_W-1:0]     count_in,
   input  logic [CENTER_W-1:0]  old_center,
   output logic                 busy,
   output logic                 done,
   output logic [CENTER_W-1:0]  new_center,
   output logic                 stable,
   output logic                 empty
);
   localparam int BC_W = $clog2(ACC_W);
   logic [1:0]          state_q, state_d;
   logic [BC_W-1:0]     bc_q, bc_d;
   logic [CNT_W-1:0]    count_q;
   logic [CENTER_W-1:0] old_q, quot, nc_d, new_center_q;
   logic [DIM_W:0]      diff [DIM];
   logic                accept, empty_d, stable_d, stable_q, empty_q, done_q;
   assign accept = state_q == ST_IDLE && start;
   assign empty_d = count_q == '0;
   assign nc_d = empty_d ? old_q : quot;
   for (genvar i = 0; i < DIM; i++) begin : g_lane
      center_div_lane #(
         .DIM_W(DIM_W),
         .CNT_W(CNT_W),
         .ACC_W(ACC_W),
         .DATA_RANGE(DATA_RANGE)
      ) u_lane (
         .clk(clk),
         .load(accept),
         .step(state_q == ST_DIV),
         .dividend(acc_in[i*ACC_W +: ACC_W]),
         .divisor(count_in),
         .quotient(quot[i*DIM_W +: DIM_W])
      );
      assign diff[i] = nc_d[i*DIM_W +: DIM_W] >= old_q[i*DIM_W +: DIM_W]
         ? {1'b0, nc_d[i*DIM_W +: DIM_W]} - {1'b0, old_q[i*DIM_W +: DIM_W]}
         : {1'b0, old_q[i*DIM_W +: DIM_W]} - {1'b0, nc_d[i*DIM_W +: DIM_W]};
   end
   always_comb begin
      stable_d = 1'b1;
      for (int k = 0; k < DIM; k++) stable_d = stable_d & (diff[k] <= (DIM_W+1)'(TOL));
   end
   always_comb begin
      state_d = accept ? (count_in == '0 ? ST_CMP : ST_DIV)
              : (state_q == ST_DIV && bc_q == '0) ? ST_CMP
              : state_q == ST_CMP ? ST_IDLE : state_q;
      bc_d = accept ? BC_W'(ACC_W - 1) : state_q == ST_DIV ? bc_q - BC_W'(1) : bc_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bc_q <= '0;
         count_q <= '0;
         old_q <= '0;
         new_center_q <= '0;
         stable_q <= 1'b0;
         empty_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bc_q <= bc_d;
         done_q <= state_q == ST_CMP;
         if (accept) begin
            count_q <= count_in;
            old_q <= old_center;
         end
         if (state_q == ST_CMP) begin
            new_center_q <= nc_d;
            stable_q <= stable_d;
            empty_q <= empty_d;
         end
      end
   end
   assign busy = state_q != ST_IDLE;
   assign done = done_q;
   assign new_center = new_center_q;
   assign stable = stable_q;
   assign empty = empty_q;
endmodule

// File: tb/tb_center_update.sv
// tb_center_update: directed vectors with a scoreboard monitor checking result and done latency.
module tb_center_update;
   localparam int ACC_W = 18;
   typedef struct {
      logic [23:0] nc;
      logic        st;
      logic        em;
      int          cyc;
   } exp_t;
   logic        clk = 0, rst = 1, start = 0, start1 = 0;
   logic [53:0] acc_in = '0;
   logic [9:0]  count_in = '0;
   logic [23:0] old_center = '0;
   logic        busy, done, stable, empty, busy1, done1, stable1, empty1;
   logic [23:0] new_center, new_center1;
   exp_t        q0[$], q1[$];
   int          checks = 0, errors = 0, cyc = 0, done_cnt = 0;
   logic        done_prev = 0, done1_prev = 0;

   center_update #(.TOL(0)) dut (
      .clk(clk), .rst(rst), .start(start), .acc_in(acc_in), .count_in(count_in),
      .old_center(old_center), .busy(busy), .done(done), .new_center(new_center),
      .stable(stable), .empty(empty)
   );
   center_update #(.TOL(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .acc_in(acc_in), .count_in(count_in),
      .old_center(old_center), .busy(busy1), .done(done1), .new_center(new_center1),
      .stable(stable1), .empty(empty1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   function automatic logic [53:0] pa(input int a0, input int a1, input int a2);
      return {18'(a2), 18'(a1), 18'(a0)};
   endfunction
   function automatic logic [23:0] pc(input int c0, input int c1, input int c2);
      return {8'(c2), 8'(c1), 8'(c0)};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         done_cnt++;
         chk("done_width", 32'(done_prev), 0);
         if (q0.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = q0.pop_front();
            chk("new_center", 32'(new_center), 32'(e.nc));
            chk("stable", 32'(stable), 32'(e.st));
            chk("empty", 32'(empty), 32'(e.em));
            chk("done_cycle", cyc, e.cyc);
         end
      end
      done_prev = done;
   end

   always @(negedge clk) begin
      exp_t e;
      if (done1) begin
         chk("done1_width", 32'(done1_prev), 0);
         if (q1.size() == 0) chk("unexpected_done1", 1, 0);
         else begin
            e = q1.pop_front();
            chk("new_center1", 32'(new_center1), 32'(e.nc));
            chk("stable1", 32'(stable1), 32'(e.st));
            chk("empty1", 32'(empty1), 32'(e.em));
            chk("done1_cycle", cyc, e.cyc);
         end
      end
      done1_prev = done1;
   end

   // Called away from the rising edge; returns just after the accept edge with operands scrambled.
   task automatic issue(input bit s1, input logic [53:0] a, input logic [9:0] c, input logic [23:0] o,
                        input logic [23:0] en, input bit es, input bit em, input bit push);
      exp_t e;
      acc_in = a;
      count_in = c;
      old_center = o;
      if (s1) start1 = 1;
      else start = 1;
      e.nc = en;
      e.st = es;
      e.em = em;
      e.cyc = cyc + 1 + (c == 0 ? 1 : ACC_W + 1);
      if (push && s1) q1.push_back(e);
      if (push && !s1) q0.push_back(e);
      @(posedge clk);
      #1;
      start = 0;
      start1 = 0;
      acc_in = '1;
      count_in = '1;
      old_center = '1;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      chk("drain", q0.size() + q1.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      int dc;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_new_center", 32'(new_center), 0);
      chk("rst_stable", 32'(stable), 0);
      chk("rst_empty", 32'(empty), 0);
      rst = 0;
      @(negedge clk);
      issue(0, pa(300, 600, 765), 3, pc(100, 200, 255), pc(100, 200, 255), 1, 0, 1);
      drain();
      issue(0, pa(10, 11, 0), 4, pc(2, 3, 0), pc(2, 2, 0), 0, 0, 1);
      @(negedge clk);
      issue(1, pa(10, 11, 0), 4, pc(2, 3, 0), pc(2, 2, 0), 1, 0, 1);
      drain();
      issue(0, pa(50, 50, 50), 0, pc(7, 8, 9), pc(7, 8, 9), 1, 1, 1);
      @(negedge clk);
      chk("busy_empty_e0", 32'(busy), 1);
      @(negedge clk);
      chk("busy_empty_e1", 32'(busy), 0);
      drain();
      issue(0, pa(1000, 0, 0), 1, pc(0, 0, 0), pc(255, 0, 0), 0, 0, 1);
      drain();
      issue(0, pa(300, 600, 765), 3, pc(100, 200, 255), pc(100, 200, 255), 1, 0, 1);
      repeat (5) @(negedge clk);
      issue(0, pa(1000, 0, 0), 1, pc(0, 0, 0), pc(255, 0, 0), 0, 0, 0);
      @(negedge clk);
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      chk("wait_first_done", 32'(done), 1);
      issue(0, pa(10, 11, 0), 4, pc(2, 3, 0), pc(2, 2, 0), 0, 0, 1);
      drain();
      issue(0, pa(300, 600, 765), 3, pc(100, 200, 255), pc(100, 200, 255), 1, 0, 0);
      repeat (5) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_new_center", 32'(new_center), 0);
      chk("abort_stable", 32'(stable), 0);
      dc = done_cnt;
      repeat (40) @(negedge clk);
      chk("abort_no_done", done_cnt, dc);
      issue(0, pa(1000, 0, 0), 1, pc(0, 0, 0), pc(255, 0, 0), 0, 0, 1);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/center_update.md
# center_update

Per-node centroid update unit for the kd-tree k-means array. When a cluster processing element finishes an iteration, this block takes its per-axis coordinate accumulators and point count and computes the new center by iterative restoring division, all axes in parallel. It then compares the new center against the old center for local stability. The result is returned to the processing element, which commits it as its center for the next iteration.

## Interface
- dim, 3, number of axes; the block supports 1..4
- data_range, 255, maximum coordinate value; DIM_W = $clog2(data_range)
- max_n, 1000, maximum points per cluster; CNT_W = $clog2(max_n)
- tol, 0, maximum per-axis |new − old| that still counts as stable; width DIM_W
- ACC_W = DIM_W + CNT_W; CENTER_W = dim*DIM_W (derived localparams)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when busy=0
- acc_in  in  dim*ACC_W  packed accumulators; axis i at [i*ACC_W +: ACC_W]
- count_in  in  CNT_W  number of points accumulated
- old_center  in  CENTER_W  current center; axis i at [i*DIM_W +: DIM_W]
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the result is valid
- new_center  out  CENTER_W  computed center; held until the next accepted start
- stable  out  1  every axis satisfies |new − old| ≤ tol; held with new_center
- empty  out  1  the last accepted request had count_in == 0; held

## Operation
- States: IDLE, DIV, CMP.
- IDLE, start=1: latch acc_in, count_in and old_center.
  - If count_in == 0, go to CMP.
  - Otherwise, clear the quotient and remainder registers, load bit counter = ACC_W−1, and go to DIV.
- DIV: each cycle, every lane does one restoring step, MSB first.
  - rem' = {rem, dividend bit}.
  - If rem' ≥ count, subtract count and shift in quotient bit 1; otherwise shift in 0.
  - After the cycle in which the bit counter reaches 0, go to CMP.
- Arithmetic:
  - Quotient is truncated (floor).
  - Quotient is ACC_W wide. If it exceeds data_range, saturate to data_range.
  - Remainder register is CNT_W+1 bits wide.
- CMP:
  - If count == 0, new_center = latched old_center and empty = 1; otherwise empty = 0.
  - Compute per-axis absolute difference, unsigned, in DIM_W+1 bits.
  - stable = AND over axes of (diff ≤ tol).
  - Register new_center, stable and empty; pulse done; go to IDLE.
- Start while busy=1 is ignored; no queuing, and in-flight operands are unaffected.
- start in the same cycle as done is accepted, since the state is already IDLE.
- Reset, including mid-DIV or mid-CMP:
  - state = IDLE; busy = 0, done = 0, stable = 0, empty = 0, new_center = 0.
  - No done pulse follows for the aborted request.
- Operand inputs are sampled only in the accept cycle. Later changes have no effect on the result.

## Timing
- Accept at rising edge E0 (IDLE, start=1).
- count ≠ 0:
  - DIV occupies ACC_W cycles.
  - done is high for exactly one cycle, beginning ACC_W+1 edges after E0.
  - Default parameters: ACC_W = 18, so done is high in cycle 19 after the accept edge.
- count = 0: done is high in the cycle following E0+1, i.e. 2 cycles after start.
- busy rises the cycle after E0 and falls in the same cycle done rises.
- new_center, stable and empty change only at the edge that raises done.
- Reset values: all outputs 0.

## Structure
- Shared package kd_pkg holds:
  - DIM_W / CNT_W / ACC_W derivation functions.
  - State encoding localparams (IDLE, DIV, CMP).
  - Default dim, data_range and max_n, shared with the cluster PE and tree controller.
- Sub-module center_div_lane: one restoring-division lane.
  - Ports: clk, load, step, dividend, divisor, quotient (saturated to DIM_W).
  - Instantiated dim times under a generate loop.
- The top level holds the FSM, bit counter, stability compare and output registers.

## Test plan
- Stable: acc = (300, 600, 765), count = 3, old = (100, 200, 255), tol = 0 → new = (100, 200, 255), stable = 1, empty = 0, done 19 cycles after start, one cycle wide.
- Truncation: acc = (10, 11, 0), count = 4, old = (2, 3, 0).
  - tol = 0 → new = (2, 2, 0), stable = 0.
  - Rerun with tol = 1 → stable = 1.
- Empty cluster: count = 0, old = (7, 8, 9) → new = (7, 8, 9), stable = 1, empty = 1, done 2 cycles after start, busy high for exactly 1 cycle.
- Saturation: acc = (1000, 0, 0), count = 1, old = 0 → new = (255, 0, 0), stable = 0.
- Protocol:
  - start pulsed during DIV with different operands → ignored; the first result is unchanged.
  - A second start in the done cycle is accepted, with its done 19 cycles later.
- Reset: assert rst at DIV cycle 5 → next cycle busy = 0 and new_center = 0, no done pulse within 40 cycles; a subsequent request completes normally.
